// File: rtl/delay_pkg.sv
// Shared types and constants for the delay-line parameter controller.
package delay_pkg;

    localparam int MAX_LOOP_DEFAULT = 48000;
    localparam int FB_W             = 16;
    localparam int LOOP_W           = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FADE_OUT = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_FADE_IN  = 2'd3
    } state_e;

    // A zero-length loop is meaningless to the delay line, so it maps to one sample.
    function automatic logic [LOOP_W-1:0] clamp_loop(input logic [LOOP_W-1:0] req,
                                                     input logic [LOOP_W-1:0] max_loop);
        logic [LOOP_W-1:0] res;
        if (req == {LOOP_W{1'b0}}) begin
            res = {{(LOOP_W-1){1'b0}}, 1'b1};
        end else if (req > max_loop) begin
            res = max_loop;
        end else begin
            res = req;
        end
        return res;
    endfunction

    function automatic logic [FB_W-1:0] clamp_fb(input logic [FB_W-1:0] req);
        logic [FB_W-1:0] res;
        if (req[FB_W-1]) begin
            res = {FB_W{1'b0}};
        end else begin
            res = req;
        end
        return res;
    endfunction

endpackage

// File: rtl/fb_ramp.sv
// Saturating feedback ramp: steps a Q1.15 register toward a target by a
// fixed amount per tick and lands exactly on the target.
module fb_ramp
    import delay_pkg::*;
#(
    parameter logic [FB_W-1:0] STEP = 16'h0200
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            tick,
    input  logic            load,
    input  logic [FB_W-1:0] target,
    output logic [FB_W-1:0] value,
    output logic            at_target
);

    logic [FB_W-1:0] value_r;
    logic [FB_W-1:0] diff_s;
    logic [FB_W-1:0] next_s;

    // Next ramp value: one step toward target, clipped so it never overshoots.
    always_comb begin
        diff_s = {FB_W{1'b0}};
        next_s = value_r;
        if (value_r < target) begin
            diff_s = target - value_r;
            if (diff_s <= STEP) begin
                next_s = target;
            end else begin
                next_s = value_r + STEP;
            end
        end else if (value_r > target) begin
            diff_s = value_r - target;
            if (diff_s <= STEP) begin
                next_s = target;
            end else begin
                next_s = value_r - STEP;
            end
        end else begin
            next_s = value_r;
        end
    end

    // Ramp register; load snaps straight to the target.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            value_r <= {FB_W{1'b0}};
        end else if (load) begin
            value_r <= target;
        end else if (tick) begin
            value_r <= next_s;
        end else begin
            value_r <= value_r;
        end
    end

    assign value     = value_r;
    assign at_target = (value_r == target);

endmodule

// File: rtl/delay_ctrl.sv
// Delay-line parameter controller: fades feedback out, flushes the loop
// memory, switches loop length and fades feedback back in.
module delay_ctrl
    import delay_pkg::*;
#(
    parameter int              MAX_LOOP     = MAX_LOOP_DEFAULT,
    parameter int              DEFAULT_LOOP = 24000,
    parameter logic [FB_W-1:0] FB_STEP      = 16'h0200
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              sample_tick,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [LOOP_W-1:0] req_looptime,
    input  logic [FB_W-1:0]   req_feedback,
    input  logic              fx_on,
    output logic              delay_enable,
    output logic [FB_W-1:0]   feedback,
    output logic [LOOP_W-1:0] looptime,
    output logic              busy
);

    localparam logic [LOOP_W-1:0] MAX_LOOP_L     = LOOP_W'(MAX_LOOP);
    localparam logic [LOOP_W-1:0] DEFAULT_LOOP_L = LOOP_W'(DEFAULT_LOOP);

    state_e            state_r;
    state_e            state_nxt_s;
    logic [LOOP_W-1:0] looptime_r;
    logic [LOOP_W-1:0] loop_tgt_r;
    logic [FB_W-1:0]   fb_tgt_r;
    logic [LOOP_W-1:0] cnt_r;
    logic              busy_r;
    logic              ready_r;
    logic              enable_r;

    logic              accept_s;
    logic [LOOP_W-1:0] req_loop_s;
    logic [FB_W-1:0]   req_fb_s;
    logic [LOOP_W-1:0] flush_len_s;
    logic [FB_W-1:0]   ramp_tgt_s;
    logic              ramp_tick_s;
    logic              ramp_load_s;
    logic [FB_W-1:0]   fb_value_s;
    logic              fb_at_tgt_s;

    // Request acceptance, clamped targets and flush length.
    always_comb begin
        accept_s    = req_valid && ready_r;
        req_loop_s  = clamp_loop(req_looptime, MAX_LOOP_L);
        req_fb_s    = clamp_fb(req_feedback);
        if (looptime_r > loop_tgt_r) begin
            flush_len_s = looptime_r;
        end else begin
            flush_len_s = loop_tgt_r;
        end
    end

    // Ramp steering: fade toward zero everywhere except FADE_IN; FLUSH pins it at zero.
    always_comb begin
        ramp_tgt_s  = {FB_W{1'b0}};
        ramp_tick_s = 1'b0;
        ramp_load_s = 1'b0;
        if (state_r == ST_FADE_IN) begin
            ramp_tgt_s = fb_tgt_r;
        end else begin
            ramp_tgt_s = {FB_W{1'b0}};
        end
        if ((state_r == ST_FADE_OUT) || (state_r == ST_FADE_IN)) begin
            ramp_tick_s = sample_tick;
        end else begin
            ramp_tick_s = 1'b0;
        end
        if (state_r == ST_FLUSH) begin
            ramp_load_s = 1'b1;
        end else begin
            ramp_load_s = 1'b0;
        end
    end

    // Next-state decode; a request edge never consumes a coincident tick since IDLE ignores ticks.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (req_loop_s != looptime_r) begin
                        state_nxt_s = ST_FADE_OUT;
                    end else begin
                        state_nxt_s = ST_FADE_IN;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FADE_OUT: begin
                if (sample_tick && fb_at_tgt_s) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_FADE_OUT;
                end
            end
            ST_FLUSH: begin
                if (sample_tick && (cnt_r <= 32'd1)) begin
                    state_nxt_s = ST_FADE_IN;
                end else begin
                    state_nxt_s = ST_FLUSH;
                end
            end
            ST_FADE_IN: begin
                if (sample_tick && fb_at_tgt_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_FADE_IN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Controller state, targets, flush counter and registered status outputs.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_r    <= ST_IDLE;
            looptime_r <= DEFAULT_LOOP_L;
            loop_tgt_r <= {LOOP_W{1'b0}};
            fb_tgt_r   <= {FB_W{1'b0}};
            cnt_r      <= {LOOP_W{1'b0}};
            busy_r     <= 1'b0;
            ready_r    <= 1'b0;
            enable_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            busy_r   <= (state_nxt_s != ST_IDLE);
            ready_r  <= (state_nxt_s == ST_IDLE);
            enable_r <= fx_on;
            if (accept_s) begin
                loop_tgt_r <= req_loop_s;
                fb_tgt_r   <= req_fb_s;
            end else begin
                loop_tgt_r <= loop_tgt_r;
                fb_tgt_r   <= fb_tgt_r;
            end
            case (state_r)
                ST_FADE_OUT: begin
                    if (sample_tick && fb_at_tgt_s) begin
                        cnt_r <= flush_len_s;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_FLUSH: begin
                    if (sample_tick) begin
                        if (cnt_r <= 32'd1) begin
                            cnt_r      <= {LOOP_W{1'b0}};
                            looptime_r <= loop_tgt_r;
                        end else begin
                            cnt_r <= cnt_r - 32'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    fb_ramp #(
        .STEP (FB_STEP)
    ) u_fb_ramp (
        .Clk       (Clk),
        .Reset     (Reset),
        .tick      (ramp_tick_s),
        .load      (ramp_load_s),
        .target    (ramp_tgt_s),
        .value     (fb_value_s),
        .at_target (fb_at_tgt_s)
    );

    assign req_ready    = ready_r;
    assign busy         = busy_r;
    assign delay_enable = enable_r;
    assign feedback     = fb_value_s;
    assign looptime     = looptime_r;

endmodule

// File: tb/tb_delay_ctrl.sv
// Directed bench for delay_ctrl: a table of parameter requests with
// hand-computed tick counts, plus hand sequences for busy/reset corners.
module tb_delay_ctrl;

    logic        Clk;
    logic        Reset;
    logic        sample_tick;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_looptime;
    logic [15:0] req_feedback;
    logic        fx_on;
    logic        delay_enable;
    logic [15:0] feedback;
    logic [31:0] looptime;
    logic        busy;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [31:0] loop;
        logic [15:0] fb;
        int          ticks;
        int          loop_tick;
        logic [31:0] exp_loop;
        logic [15:0] exp_fb;
    } vec_t;

    vec_t vecs [7];

    delay_ctrl dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .sample_tick  (sample_tick),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_looptime (req_looptime),
        .req_feedback (req_feedback),
        .fx_on        (fx_on),
        .delay_enable (delay_enable),
        .feedback     (feedback),
        .looptime     (looptime),
        .busy         (busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic idle_edge();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick_once();
        sample_tick = 1'b1;
        @(posedge Clk);
        #1;
        sample_tick = 1'b0;
    endtask

    task automatic do_request(input logic [31:0] loop, input logic [15:0] fb);
        int w;
        w = 0;
        while (!req_ready && w < 100) begin
            idle_edge();
            w++;
        end
        chk("ready_before_request", 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_looptime = loop;
        req_feedback = fb;
        idle_edge();
        req_valid    = 1'b0;
    endtask

    task automatic run_to_idle(output int n, output int lt_tick);
        logic [31:0] prev;
        prev    = looptime;
        n       = 0;
        lt_tick = 0;
        while (busy && n < 50000) begin
            tick_once();
            n++;
            if (looptime !== prev && lt_tick == 0) lt_tick = n;
            prev = looptime;
        end
    endtask

    task automatic apply_vec(input int i);
        int n;
        int lt;
        do_request(vecs[i].loop, vecs[i].fb);
        chk($sformatf("v%0d_busy_after_accept", i), 32'(busy), 32'd1);
        run_to_idle(n, lt);
        chk($sformatf("v%0d_ticks_to_idle", i), 32'(n), 32'(vecs[i].ticks));
        chk($sformatf("v%0d_looptime_switch_tick", i), 32'(lt), 32'(vecs[i].loop_tick));
        chk($sformatf("v%0d_looptime", i), looptime, vecs[i].exp_loop);
        chk($sformatf("v%0d_feedback", i), 32'(feedback), 32'(vecs[i].exp_fb));
        chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'd1);
    endtask

    initial begin
        int n;
        int lt;

        // loop, fb, ticks to idle, tick of looptime switch, final looptime, final feedback
        vecs[0] = '{32'd24000, 16'h4000, 33,    0,     32'd24000, 16'h4000};
        vecs[1] = '{32'd1000,  16'h4000, 24066, 24033, 32'd1000,  16'h4000};
        vecs[2] = '{32'd1000,  16'h1000, 25,    0,     32'd1000,  16'h1000};
        vecs[3] = '{32'd1000,  16'h1000, 1,     0,     32'd1000,  16'h1000};
        vecs[4] = '{32'd0,     16'h8000, 1010,  1009,  32'd1,     16'h0000};
        vecs[5] = '{32'd70000, 16'h0100, 48003, 48001, 32'd48000, 16'h0100};
        vecs[6] = '{32'd70000, 16'h0100, 1,     0,     32'd48000, 16'h0100};

        Reset        = 1'b0;
        sample_tick  = 1'b0;
        req_valid    = 1'b0;
        req_looptime = 32'd0;
        req_feedback = 16'h0000;
        fx_on        = 1'b1;

        repeat (3) idle_edge();
        chk("reset_looptime", looptime, 32'd24000);
        chk("reset_feedback", 32'(feedback), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ready", 32'(req_ready), 32'd0);
        chk("reset_enable", 32'(delay_enable), 32'd0);

        Reset = 1'b1;
        idle_edge();
        chk("release_ready", 32'(req_ready), 32'd1);
        chk("release_enable", 32'(delay_enable), 32'd1);
        chk("release_looptime", looptime, 32'd24000);
        fx_on = 1'b0;
        idle_edge();
        chk("enable_follows_fx_on", 32'(delay_enable), 32'd0);

        for (int i = 0; i < 5; i++) apply_vec(i);

        // Request during FLUSH is ignored, then accepted on an edge that also carries a tick.
        do_request(32'd200, 16'h0000);
        chk("busy_req_accept", 32'(busy), 32'd1);
        tick_once();
        repeat (50) tick_once();
        req_valid    = 1'b1;
        req_looptime = 32'd200;
        req_feedback = 16'h0400;
        chk("busy_req_ready_low", 32'(req_ready), 32'd0);
        tick_once();
        chk("busy_req_still_busy", 32'(busy), 32'd1);
        chk("busy_req_fb_flush", 32'(feedback), 32'd0);
        n = 0;
        while (busy && n < 1000) begin
            tick_once();
            n++;
        end
        chk("busy_req_flush_remaining", 32'(n), 32'd150);
        chk("busy_req_idle_looptime", looptime, 32'd200);
        chk("busy_req_idle_fb", 32'(feedback), 32'd0);
        chk("busy_req_idle_ready", 32'(req_ready), 32'd1);
        tick_once();
        req_valid = 1'b0;
        chk("late_accept_busy", 32'(busy), 32'd1);
        chk("late_accept_tick_not_used", 32'(feedback), 32'd0);
        tick_once();
        chk("late_accept_first_step", 32'(feedback), 32'h0200);
        run_to_idle(n, lt);
        chk("late_accept_ticks", 32'(n), 32'd2);
        chk("late_accept_fb", 32'(feedback), 32'h0400);
        chk("late_accept_looptime", looptime, 32'd200);

        // Reset in the middle of a flush abandons the loop change.
        do_request(32'd2000, 16'h0400);
        repeat (3) tick_once();
        chk("midflush_fb_zero", 32'(feedback), 32'd0);
        repeat (1500) tick_once();
        chk("midflush_busy", 32'(busy), 32'd1);
        chk("midflush_looptime_held", looptime, 32'd200);
        fx_on = 1'b1;
        Reset = 1'b0;
        idle_edge();
        chk("midflush_reset_busy", 32'(busy), 32'd0);
        chk("midflush_reset_fb", 32'(feedback), 32'd0);
        chk("midflush_reset_looptime", looptime, 32'd24000);
        chk("midflush_reset_enable", 32'(delay_enable), 32'd0);
        Reset = 1'b1;
        idle_edge();
        chk("midflush_release_ready", 32'(req_ready), 32'd1);
        chk("midflush_release_enable", 32'(delay_enable), 32'd1);
        fx_on = 1'b0;
        idle_edge();

        for (int i = 5; i < 7; i++) apply_vec(i);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
